// File: rtl/vec_pkg.sv
// Shared types and constants for the vector store sequencer.
// Optional lane-mask skipping is enabled with VEC_STORE_LANE_MASK_EN.
package vec_pkg;
    localparam int LANES       = 4;
    localparam int DATA_W      = 32;
    localparam int LANE_STRIDE = 4;

    typedef enum logic {S_IDLE, S_WRITE} seq_state_t;

    typedef logic [1:0] lane_idx_t;
endpackage

// File: rtl/next_lane_sel.sv
// Priority finder: lowest set mask bit at or above start, plus a flag when none remain.
module next_lane_sel
    import vec_pkg::*;
(
    input  logic [LANES-1:0] mask,
    input  lane_idx_t        start,
    output lane_idx_t        next_idx,
    output logic             none_left
);

    // Scanning downward leaves the lowest qualifying lane as the final assignment.
    always_comb begin
        next_idx  = '0;
        none_left = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start))) begin
                next_idx  = lane_idx_t'(i);
                none_left = 1'b0;
            end
        end
    end

endmodule

// File: rtl/vec_store_sequencer.sv
// Serialises a captured 4-lane store onto a one-word memory write port, stalling the pipeline meanwhile.
// Define VEC_STORE_LANE_MASK_EN to skip lanes whose lane_mask bit is clear.
module vec_store_sequencer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LANES  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mem_write_req,
    input  logic                    vec_sel,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [LANES*DATA_W-1:0] lane_data,
    input  logic [LANES-1:0]        lane_mask,
    input  logic                    mem_ready,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic                    stop,
    output logic                    busy,
    output logic                    done
);
    import vec_pkg::*;

    seq_state_t              state_q, state_d;
    lane_idx_t               lane_idx_q, lane_idx_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [LANES*DATA_W-1:0] data_q, data_d;
    logic [LANES-1:0]        rem_q, rem_d;
    logic                    done_q, done_d;

    logic [LANES-1:0]        req_mask;
    logic [LANES-1:0]        sel_mask;
    logic [LANES-1:0]        cur_bit;
    lane_idx_t               sel_start;
    lane_idx_t               sel_next;
    logic                    sel_none;

`ifdef VEC_STORE_LANE_MASK_EN
    assign req_mask = (vec_sel ? {LANES{1'b1}} : LANES'(1)) & lane_mask;
`else
    logic unused_lane_mask;
    assign unused_lane_mask = ^lane_mask;
    assign req_mask = vec_sel ? {LANES{1'b1}} : LANES'(1);
`endif

    assign cur_bit = LANES'(1) << lane_idx_q;

    next_lane_sel u_next_lane_sel (
        .mask      (sel_mask),
        .start     (sel_start),
        .next_idx  (sel_next),
        .none_left (sel_none)
    );

    // rem_q tracks lanes still owed a beat; the finder picks the first from it.
    always_comb begin
        state_d    = state_q;
        lane_idx_d = lane_idx_q;
        base_d     = base_q;
        data_d     = data_q;
        rem_d      = rem_q;
        done_d     = 1'b0;
        sel_mask   = rem_q & ~cur_bit;
        sel_start  = lane_idx_q;
        case (state_q)
            S_IDLE: begin
                sel_mask  = req_mask;
                sel_start = '0;
                if (mem_write_req) begin
                    base_d     = base_addr;
                    data_d     = lane_data;
                    rem_d      = req_mask;
                    lane_idx_d = sel_next;
                    if (sel_none) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (mem_ready) begin
                    rem_d = sel_mask;
                    if (sel_none) begin
                        state_d    = S_IDLE;
                        lane_idx_d = '0;
                        done_d     = 1'b1;
                    end else begin
                        lane_idx_d = sel_next;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            lane_idx_q <= '0;
            base_q     <= '0;
            data_q     <= '0;
            rem_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            lane_idx_q <= lane_idx_d;
            base_q     <= base_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            done_q     <= done_d;
        end
    end

    assign mem_we    = (state_q == S_WRITE);
    assign stop      = (state_q == S_WRITE);
    assign busy      = (state_q == S_WRITE);
    assign done      = done_q;
    assign mem_addr  = mem_we ? base_q + ADDR_W'(LANE_STRIDE * int'(lane_idx_q)) : '0;
    assign mem_wdata = mem_we ? data_q[int'(lane_idx_q)*DATA_W +: DATA_W] : '0;

endmodule

// File: doc/vec_store_sequencer.md
Name: vec_store_sequencer

Overview:
Serialises the 4-lane store result held in the EXE/MEM pipeline register onto the single-word data-memory write port, one lane per beat. Sits in the MEM stage between the EXE/MEM register outputs and data memory. Drives the pipeline `stop` line while a multi-beat store is in flight, so upstream pipeline registers hold. Issues a one-cycle completion pulse per store instruction.

Parameters:
- DATA_W, 32: lane and memory data width.
- ADDR_W, 32: byte address width.
- LANES, 4: number of vector lanes.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- mem_write_req  in  1  store request (memWrite_out of EXE/MEM).
- vec_sel  in  1  1 = store all lanes; 0 = scalar store of lane 0 only (select_out).
- base_addr  in  ADDR_W  byte address of lane 0.
- lane_data  in  LANES*DATA_W  lane i at [i*DATA_W +: DATA_W] (aluRes0..3).
- lane_mask  in  LANES  per-lane enable (resCompare_out); used only under the optional feature.
- mem_ready  in  1  memory accepts the current beat.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  beat address.
- mem_wdata  out  DATA_W  beat data.
- stop  out  1  stall to pipeline registers.
- busy  out  1  sequencer not idle.
- done  out  1  one-cycle pulse after the last beat of a store is accepted.

Behaviour:
- Reset: asynchronous; state S_IDLE. mem_we, mem_addr, mem_wdata, stop, busy, done, lane index and captured operands all 0. A reset mid-store aborts it; pending beats are dropped with no further writes.
- S_IDLE: mem_write_req is sampled at the rising edge. If it is 1, capture base_addr, lane_data, vec_sel (and lane_mask) and go to S_WRITE at that edge. stop is 0 in S_IDLE, so the EXE/MEM register advances at the capture edge.
- S_WRITE:
  - stop = busy = mem_we = 1.
  - mem_addr = base + 4*lane_idx, computed modulo 2^ADDR_W (wraps).
  - mem_wdata = captured lane[lane_idx].
  - A beat completes at an edge where mem_we && mem_ready. Then lane_idx advances to the next lane.
  - After the last lane (lane 3 for vector, lane 0 for scalar) completes, go to S_IDLE and set done=1 for exactly one cycle.
- Backpressure: while mem_ready=0, mem_we, mem_addr and mem_wdata stay stable and stop stays 1.
- mem_write_req is ignored while in S_WRITE. The frozen next instruction is re-sampled once the sequencer is back in S_IDLE. A request present in the cycle done=1 is captured at that edge (back-to-back stores, no bubble).
- Latency: with mem_ready=1, a vector store gives 4 beats and 4 stall cycles, with done in the cycle after the last beat. A scalar store gives 1 beat and 1 stall cycle.
- stop, mem_we and busy are decoded from registered state only; no combinational path from inputs.

Optional Feature:
- Macro VEC_STORE_LANE_MASK_EN.
- Defined: lanes whose lane_mask bit is 0 are skipped with no beat and no cycle. The lane index jumps to the next enabled lane. A scalar store writes only if mask[0]=1. If no lane is enabled, the sequencer stays in S_IDLE, stop is never asserted, and done pulses the cycle after capture.
- Undefined: lane_mask is ignored; all lanes selected by vec_sel are written.

Decomposition:
- Shared package vec_pkg holds:
  - LANES and DATA_W constants.
  - LANE_STRIDE = 4.
  - typedef enum seq_state_t {S_IDLE, S_WRITE}.
  - typedef lane_idx_t, 2 bits.
- Sub-module next_lane_sel: a combinational priority finder that returns the next enabled lane index at or above a given index, plus a none-left flag. It is natural for the mask feature, and without the mask the same module is used with an all-ones mask.

Test Plan:
- Reset: assert reset mid-cycle → all outputs 0 immediately; they remain 0 after release with mem_write_req=0.
- Vector store, base 0x100, lanes AAAABBBB/CCCCDDDD/EEEEFFFF/11112222, mem_ready=1:
  - Request captured at edge 0.
  - Cycles 1–4: mem_we=1, stop=1, addr 0x100/0x104/0x108/0x10C with data in lane order.
  - Cycle 5: done=1, stop=0.
- Scalar store vec_sel=0, base 0x20 → one beat at addr 0x20 with data AAAABBBB, stop high for 1 cycle, then done.
- Backpressure: vector store at 0x100 with mem_ready=0 for 2 cycles during beat 1 → addr 0x104/CCCCDDDD held for 3 cycles, stop high for 6 cycles total, 4 writes.
- Wrap and abort:
  - base 0xFFFFFFF8 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4.
  - reset asserted during beat 2 → mem_we drops at once, no further writes, no done.
  - A following request is then handled normally.
- With VEC_STORE_LANE_MASK_EN:
  - mask 4'b1010, base 0x100 → beats 0x104/CCCCDDDD and 0x10C/11112222, stop for 2 cycles.
  - mask 4'b0000 → no beats, stop stays 0, done pulses one cycle after capture.
